cmp_arbiter: RTL and testbench

CMP_ARBITER -- requirements
Module: cmp_arbiter

---
 rtl/cmp_arbiter.sv | 138 +++++++++++++
 tb/tb_cmp_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: two request ports share a single 32-bit less-than comparator.
// Each operation is one IDLE/EXEC/RESP pass, so a request is issued at most
// every three cycles.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | waiting for a request; the granted port sees req_ready
//   EXEC  | comparator works on the captured operands; result registered
//   RESP  | result presented to the owner port until it accepts

module cmp_arbiter_cmp32 (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        is_signed_i,
   output logic        lt_o
);
   // Two's-complement or magnitude compare on the full 32 bits, no extension
   always_comb begin
      lt_o = is_signed_i ? ($signed(a_i) < $signed(b_i)) : (a_i < b_i);
   end
endmodule

module cmp_arbiter #(
   parameter int   FAIR    = 1,
   parameter logic RR_INIT = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [1:0][31:0] req_a,
   input  logic [1:0][31:0] req_b,
   input  logic [1:0]       req_signed,
   output logic [1:0]       rsp_valid,
   output logic             rsp_lt,
   input  logic [1:0]       rsp_ready,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        owner_q;
   logic        prio_q;
   logic [31:0] a_q, b_q;
   logic        signed_q;
   logic        lt_q;
   logic        gnt;
   logic        accept;
   logic        rsp_done;
   logic        cmp_lt;

   cmp_arbiter_cmp32 u_cmp (
      .a_i         (a_q),
      .b_i         (b_q),
      .is_signed_i (signed_q),
      .lt_o        (cmp_lt)
   );

   // Pick the port to serve; only meaningful when some req_valid bit is set
   always_comb begin
      gnt = 1'b0;
      unique case (req_valid)
         2'b01:   gnt = 1'b0;
         2'b10:   gnt = 1'b1;
         2'b11:   gnt = (FAIR != 0) ? prio_q : 1'b0;
         default: gnt = 1'b0;
      endcase
   end

   // The granted port always has its valid set, so any valid in IDLE is a transfer
   assign accept   = (state_q == ST_IDLE) && (|req_valid) && rst_n;
   assign rsp_done = (state_q == ST_RESP) && rsp_ready[owner_q];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; RESP always falls back to IDLE so there is no bypass
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept)   state_d = ST_EXEC;
         ST_EXEC:               state_d = ST_RESP;
         ST_RESP: if (rsp_done) state_d = ST_IDLE;
         default:               state_d = ST_IDLE;
      endcase
   end

   // Outputs; req_ready is gated by rst_n so it drops the moment reset asserts
   always_comb begin
      req_ready = 2'b00;
      rsp_valid = 2'b00;
      busy      = (state_q != ST_IDLE);
      rsp_lt    = lt_q;
      if (accept) begin
         req_ready[gnt] = 1'b1;
      end
      if (state_q == ST_RESP) begin
         rsp_valid[owner_q] = 1'b1;
      end
   end

   // Operand capture, result register and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q  <= 1'b0;
         prio_q   <= RR_INIT;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         signed_q <= 1'b0;
         lt_q     <= 1'b0;
      end else begin
         if (accept) begin
            owner_q  <= gnt;
            a_q      <= req_a[gnt];
            b_q      <= req_b[gnt];
            signed_q <= req_signed[gnt];
         end
         if (state_q == ST_EXEC) begin
            lt_q <= cmp_lt;
         end
         if (rsp_done && (FAIR != 0)) begin
            prio_q <= ~owner_q;
         end
      end
   end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: a round-robin instance and a fixed-priority
// instance driven by the same stimulus.

module tb_cmp_arbiter;

   logic             clk;
   logic             rst_n;
   logic [1:0]       req_valid;
   logic [1:0][31:0] req_a;
   logic [1:0][31:0] req_b;
   logic [1:0]       req_signed;
   logic [1:0]       rsp_ready;

   logic [1:0] rr_req_ready, rr_rsp_valid;
   logic       rr_rsp_lt, rr_busy;
   logic [1:0] fp_req_ready, fp_rsp_valid;
   logic       fp_rsp_lt, fp_busy;

   int total = 0;
   int bad   = 0;

   cmp_arbiter #(.FAIR(1), .RR_INIT(1'b0)) dut_rr (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (rr_req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_signed (req_signed),
      .rsp_valid  (rr_rsp_valid),
      .rsp_lt     (rr_rsp_lt),
      .rsp_ready  (rsp_ready),
      .busy       (rr_busy)
   );

   cmp_arbiter #(.FAIR(0), .RR_INIT(1'b0)) dut_fp (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (fp_req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_signed (req_signed),
      .rsp_valid  (fp_rsp_valid),
      .rsp_lt     (fp_rsp_lt),
      .rsp_ready  (rsp_ready),
      .busy       (fp_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One uncontended operation on port p with rsp_ready held high
   task automatic run_single(input string tag, input int p, input logic [31:0] a,
                             input logic [31:0] b, input logic s, input logic exp_lt);
      logic [1:0] onehot;
      onehot = 2'b00;
      onehot[p] = 1'b1;
      req_valid = onehot;
      req_a[p] = a;
      req_b[p] = b;
      req_signed[p] = s;
      rsp_ready = 2'b11;
      #1;
      chk({tag, "_ready"}, rr_req_ready, onehot);
      tick();
      req_valid = 2'b00;
      #1;
      chk({tag, "_exec_busy"}, rr_busy, 1'b1);
      chk({tag, "_exec_ready"}, rr_req_ready, 2'b00);
      chk({tag, "_exec_rspv"}, rr_rsp_valid, 2'b00);
      tick();
      chk({tag, "_rspv"}, rr_rsp_valid, onehot);
      chk({tag, "_lt"}, rr_rsp_lt, exp_lt);
      tick();
      chk({tag, "_idle_busy"}, rr_busy, 1'b0);
      chk({tag, "_idle_rspv"}, rr_rsp_valid, 2'b00);
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 2'b11;
      req_a      = '0;
      req_b      = '0;
      req_signed = 2'b00;
      rsp_ready  = 2'b00;
      #2;
      chk("rst_req_ready", rr_req_ready, 2'b00);
      chk("rst_rsp_valid", rr_rsp_valid, 2'b00);
      chk("rst_busy", rr_busy, 1'b0);
      chk("rst_rsp_lt", rr_rsp_lt, 1'b0);
      tick();
      req_valid = 2'b00;
      rst_n = 1'b1;

      // Signed / unsigned compares
      run_single("signed_m1_lt_1", 0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1);
      run_single("unsigned_max_lt_1", 0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      run_single("signed_eq_8000", 0, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
      run_single("unsigned_eq_8000", 1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
      run_single("signed_min_lt_max", 1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1);
      run_single("unsigned_min_gt_max", 1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0);

      // Fresh reset so the round-robin pointer starts at port 0
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;

      // Contention: both ports valid continuously
      req_valid = 2'b11;
      req_a[0] = 32'd1;  req_b[0] = 32'd2;  req_signed[0] = 1'b0;
      req_a[1] = 32'd4;  req_b[1] = 32'd3;  req_signed[1] = 1'b0;
      rsp_ready = 2'b11;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("cont%0d_rr_grant", k), rr_req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
         chk($sformatf("cont%0d_fp_grant", k), fp_req_ready, 2'b01);
         tick();
         chk($sformatf("cont%0d_exec_ready", k), rr_req_ready, 2'b00);
         tick();
         chk($sformatf("cont%0d_rr_rspv", k), rr_rsp_valid, (k % 2 == 1) ? 2'b10 : 2'b01);
         chk($sformatf("cont%0d_rr_lt", k), rr_rsp_lt, (k % 2 == 1) ? 1'b0 : 1'b1);
         chk($sformatf("cont%0d_fp_rspv", k), fp_rsp_valid, 2'b01);
         chk($sformatf("cont%0d_nobypass", k), rr_req_ready, 2'b00);
         tick();
      end
      req_valid = 2'b00;

      // Backpressure on port 1
      req_valid = 2'b10;
      req_a[1] = 32'd5;  req_b[1] = 32'd7;  req_signed[1] = 1'b0;
      rsp_ready = 2'b00;
      #1;
      chk("bp_grant", rr_req_ready, 2'b10);
      tick();
      req_valid = 2'b11;
      tick();
      for (int i = 0; i < 5; i++) begin
         rsp_ready = (i % 2 == 1) ? 2'b01 : 2'b00;
         #1;
         chk($sformatf("bp%0d_rspv", i), rr_rsp_valid, 2'b10);
         chk($sformatf("bp%0d_lt", i), rr_rsp_lt, 1'b1);
         chk($sformatf("bp%0d_busy", i), rr_busy, 1'b1);
         chk($sformatf("bp%0d_ready", i), rr_req_ready, 2'b00);
         tick();
      end
      rsp_ready = 2'b10;
      req_valid = 2'b00;
      #1;
      chk("bp_last_rspv", rr_rsp_valid, 2'b10);
      tick();
      chk("bp_done_busy", rr_busy, 1'b0);
      chk("bp_done_rspv", rr_rsp_valid, 2'b00);

      // Operand stability after acceptance
      req_valid = 2'b01;
      req_a[0] = 32'd1;  req_b[0] = 32'd2;  req_signed[0] = 1'b0;
      rsp_ready = 2'b11;
      tick();
      req_a[0] = 32'd9;
      req_b[0] = 32'd2;
      req_valid = 2'b00;
      tick();
      chk("stab_rspv", rr_rsp_valid, 2'b01);
      chk("stab_lt", rr_rsp_lt, 1'b1);
      tick();

      // Reset during EXEC; pointer was 1 before, must come back as 0
      req_valid = 2'b01;
      req_a[0] = 32'hFFFF_FFFB;  req_b[0] = 32'hFFFF_FFFD;  req_signed[0] = 1'b1;
      req_a[1] = 32'd0;          req_b[1] = 32'd0;          req_signed[1] = 1'b0;
      tick();
      chk("rstx_pre_busy", rr_busy, 1'b1);
      chk("rstx_pre_lt", rr_rsp_lt, 1'b1);
      #2;
      rst_n = 1'b0;
      req_valid = 2'b11;
      #1;
      chk("rstx_busy", rr_busy, 1'b0);
      chk("rstx_rspv", rr_rsp_valid, 2'b00);
      chk("rstx_lt", rr_rsp_lt, 1'b0);
      chk("rstx_ready", rr_req_ready, 2'b00);
      tick();
      chk("rstx_hold_rspv", rr_rsp_valid, 2'b00);
      rst_n = 1'b1;
      req_valid = 2'b00;
      tick();
      chk("rstx_after1_rspv", rr_rsp_valid, 2'b00);
      tick();
      chk("rstx_after2_rspv", rr_rsp_valid, 2'b00);
      chk("rstx_after2_busy", rr_busy, 1'b0);
      req_valid = 2'b11;
      #1;
      chk("rstx_prio_init", rr_req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      tick();
      chk("rstx_next_rspv", rr_rsp_valid, 2'b01);
      chk("rstx_next_lt", rr_rsp_lt, 1'b1);
      tick();
      chk("rstx_next_idle", rr_busy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
